// File: rtl/imem_loader.sv
// Length-prefixed big-endian byte-stream loader for the MIPS instruction memory; holds the core in reset while loading.
// Optional trailing XOR checksum byte when IMEM_LOADER_CKSUM_EN is defined.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W+1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_run,
  output logic              busy,
  output logic              done,
  output logic              err
);

`ifdef IMEM_LOADER_CKSUM_EN
  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, DONE, ERR, CHK} state_t;
`else
  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, DONE, ERR} state_t;
`endif

  localparam logic [16:0] MAX_LEN = 17'(2 ** ADDR_W);

  state_t            state, state_n;
  logic [15:0]       len;
  logic [15:0]       len_next;
  logic [ADDR_W:0]   word_cnt;
  logic [1:0]        byte_cnt;
  logic [23:0]       shift;
  logic              accept;
  logic              load_start;
  logic              last_wr;
`ifdef IMEM_LOADER_CKSUM_EN
  logic [7:0]        cksum;
`endif

  assign accept     = in_valid && in_ready;
  assign load_start = start && (state == IDLE || state == DONE || state == ERR);
  assign len_next   = {len[15:8], in_data};
  // word_cnt has already advanced when the strobe is high, so it equals len on the final write
  assign last_wr    = imem_we && (word_cnt == len[ADDR_W:0]);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    cpu_run  = 1'b0;
    case (state)
      IDLE: begin
        if (load_start) state_n = LEN_HI;
      end
      LEN_HI: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) state_n = LEN_LO;
      end
      LEN_LO: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          if (len_next == 16'd0) begin
`ifdef IMEM_LOADER_CKSUM_EN
            state_n = CHK;
`else
            state_n = DONE;
`endif
          end else if ({1'b0, len_next} > MAX_LEN) begin
            state_n = ERR;
          end else begin
            state_n = DATA;
          end
        end
      end
      DATA: begin
        busy     = 1'b1;
        // hold off any byte beyond the image while the final word is written
        in_ready = !last_wr;
        if (last_wr) begin
`ifdef IMEM_LOADER_CKSUM_EN
          state_n = CHK;
`else
          state_n = DONE;
`endif
        end
      end
`ifdef IMEM_LOADER_CKSUM_EN
      CHK: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) state_n = (in_data == cksum) ? DONE : ERR;
      end
`endif
      DONE: begin
        done    = 1'b1;
        cpu_run = 1'b1;
        if (load_start) state_n = LEN_HI;
      end
      ERR: begin
        err = 1'b1;
        if (load_start) state_n = LEN_HI;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len        <= '0;
      word_cnt   <= '0;
      byte_cnt   <= '0;
      shift      <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
`ifdef IMEM_LOADER_CKSUM_EN
      cksum      <= '0;
`endif
    end else begin
      imem_we <= 1'b0;
      if (load_start) begin
        word_cnt <= '0;
        byte_cnt <= '0;
`ifdef IMEM_LOADER_CKSUM_EN
        cksum    <= '0;
`endif
      end
      if (state == LEN_HI && accept) len[15:8] <= in_data;
      if (state == LEN_LO && accept) len[7:0]  <= in_data;
      if (state == DATA && accept) begin
        byte_cnt <= byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CKSUM_EN
        cksum    <= cksum ^ in_data;
`endif
        if (byte_cnt == 2'd3) begin
          imem_we    <= 1'b1;
          imem_wdata <= {shift, in_data};
          imem_addr  <= {word_cnt[ADDR_W-1:0], 2'b00};
          word_cnt   <= word_cnt + (ADDR_W+1)'(1);
        end else begin
          shift <= {shift[15:0], in_data};
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table of load scenarios plus reset-mid-word and checksum sequences.
// Expected writes go into a scoreboard queue as bytes are driven and are popped by a write monitor.
module tb_imem_loader;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = '0;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W+1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_run;
  logic              busy;
  logic              done;
  logic              err;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_run(cpu_run), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    string       name;
    logic [15:0] len;
    int unsigned gap_pct;
    logic        exp_err;
    int          exp_writes;
  } vec_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;
  int   wr_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  function automatic logic [31:0] word_of(input int unsigned k);
    logic [7:0] b;
    b = k[7:0];
    if (k == 0) return 32'h20080005;
    if (k == 1) return 32'hAC080000;
    return {b ^ 8'h5A, 8'hC3, b, ~b};
  endfunction

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      exp_t e;
      wr_cnt++;
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL unexpected_write: got addr %h data %h, required no write", imem_addr, imem_wdata);
      end else begin
        e = sb.pop_front();
        chk("write_addr", 32'(imem_addr), 32'(e.addr));
        chk("write_data", imem_wdata, e.data);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int unsigned gap_pct);
    int unsigned t;
    for (int i = 0; i < 3 && $urandom_range(99) < gap_pct; i++) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (in_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (in_ready !== 1'b1) begin
      checks++;
      $display("FAIL send_byte_timeout: in_ready=%b required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int unsigned gap_pct);
    send_byte(w[31:24], gap_pct);
    send_byte(w[23:16], gap_pct);
    send_byte(w[15:8], gap_pct);
    send_byte(w[7:0], gap_pct);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end();
    int unsigned t;
    t = 0;
    while (done !== 1'b1 && err !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (done !== 1'b1 && err !== 1'b1) begin
      checks++;
      $display("FAIL wait_end_timeout: done=%b err=%b required one of them 1", done, err);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[7];
    exp_t        e;
    logic [7:0]  x;
    logic [31:0] w;

    vecs[0] = '{"basic",     16'h0002,  0, 1'b0, 2};
    vecs[1] = '{"throttled", 16'h0002, 50, 1'b0, 2};
    vecs[2] = '{"full_mem",  16'h0100,  0, 1'b0, 256};
    vecs[3] = '{"too_long",  16'h0101,  0, 1'b1, 0};
    vecs[4] = '{"zero_len",  16'h0000,  0, 1'b0, 0};
    vecs[5] = '{"restart5",  16'h0005, 30, 1'b0, 5};
    vecs[6] = '{"huge_len",  16'hFFFF, 40, 1'b1, 0};

    repeat (3) @(negedge clk);
    chk("reset_in_ready", 32'(in_ready), 0);
    chk("reset_imem_we", 32'(imem_we), 0);
    chk("reset_addr", 32'(imem_addr), 0);
    chk("reset_wdata", imem_wdata, 0);
    chk("reset_flags", {28'd0, cpu_run, busy, done, err}, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      wr_cnt = 0;
      pulse_start();
      chk({vecs[v].name, "_start_busy"}, 32'(busy), 1);
      chk({vecs[v].name, "_start_cpu_run"}, 32'(cpu_run), 0);
      chk({vecs[v].name, "_start_done_err"}, {30'd0, done, err}, 0);
      send_byte(vecs[v].len[15:8], vecs[v].gap_pct);
      send_byte(vecs[v].len[7:0], vecs[v].gap_pct);
      x = 8'h00;
      if (!vecs[v].exp_err) begin
        for (int unsigned k = 0; k < 32'(vecs[v].len); k++) begin
          w = word_of(k);
          e.addr = 10'(k * 4);
          e.data = w;
          sb.push_back(e);
          x = x ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
          send_word(w, vecs[v].gap_pct);
        end
`ifdef IMEM_LOADER_CKSUM_EN
        send_byte(x, vecs[v].gap_pct);
`endif
      end else begin
        in_valid = 1'b1;
        in_data  = 8'hEE;
      end
      wait_end();
      in_valid = 1'b0;
      chk({vecs[v].name, "_done"}, 32'(done), 32'(!vecs[v].exp_err));
      chk({vecs[v].name, "_err"}, 32'(err), 32'(vecs[v].exp_err));
      chk({vecs[v].name, "_cpu_run"}, 32'(cpu_run), 32'(!vecs[v].exp_err));
      chk({vecs[v].name, "_busy"}, 32'(busy), 0);
      chk({vecs[v].name, "_in_ready"}, 32'(in_ready), 0);
      chk({vecs[v].name, "_write_count"}, 32'(wr_cnt), 32'(vecs[v].exp_writes));
      chk({vecs[v].name, "_sb_empty"}, 32'(sb.size()), 0);
      if (vecs[v].exp_writes > 0) begin
        chk({vecs[v].name, "_addr_hold"}, 32'(imem_addr), 32'((vecs[v].exp_writes - 1) * 4));
        chk({vecs[v].name, "_wdata_hold"}, imem_wdata, word_of(vecs[v].exp_writes - 1));
      end
    end

    // reset after two bytes of word 1: only word 0 may be written
    wr_cnt = 0;
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    e.addr = 10'h000;
    e.data = 32'h11223344;
    sb.push_back(e);
    send_word(32'h11223344, 0);
    send_byte(8'h55, 0);
    send_byte(8'h66, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_imem_we", 32'(imem_we), 0);
    chk("rst_mid_flags", {28'd0, cpu_run, busy, done, err}, 0);
    chk("rst_mid_in_ready", 32'(in_ready), 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_mid_write_count", 32'(wr_cnt), 1);
    chk("rst_mid_sb_empty", 32'(sb.size()), 0);

    wr_cnt = 0;
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    e.addr = 10'h000;
    e.data = 32'h12345678;
    sb.push_back(e);
    send_word(32'h12345678, 0);
`ifdef IMEM_LOADER_CKSUM_EN
    send_byte(8'h08, 0);
`endif
    wait_end();
    chk("fresh_done", 32'(done), 1);
    chk("fresh_cpu_run", 32'(cpu_run), 1);
    chk("fresh_write_count", 32'(wr_cnt), 1);
    chk("fresh_sb_empty", 32'(sb.size()), 0);

`ifdef IMEM_LOADER_CKSUM_EN
    wr_cnt = 0;
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    e.addr = 10'h000;
    e.data = 32'h12345678;
    sb.push_back(e);
    send_word(32'h12345678, 0);
    send_byte(8'h09, 0);
    wait_end();
    chk("bad_cksum_err", 32'(err), 1);
    chk("bad_cksum_done", 32'(done), 0);
    chk("bad_cksum_cpu_run", 32'(cpu_run), 0);
    chk("bad_cksum_write_count", 32'(wr_cnt), 1);
    chk("bad_cksum_sb_empty", 32'(sb.size()), 0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Byte-stream program loader that writes the instruction memory fetched by the single-cycle MIPS core.
- Receives a length-prefixed big-endian image over a valid/ready byte interface and packs it into 32-bit words.
- Issues one write per word at sequential word-aligned byte addresses, then releases the core to run from PC 0.
- Owns the core's run gate: the core is held in reset while a load is in progress.

Parameters:
- ADDR_W, 8, word-address width; instruction memory depth = 2**ADDR_W words.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse; begins a load from IDLE, DONE or ERR
- in_valid  input  1  byte on in_data is valid
- in_data  input  8  stream byte
- in_ready  output  1  loader accepts a byte this cycle; transfer occurs when in_valid && in_ready
- imem_we  output  1  instruction memory write strobe, one cycle per word
- imem_addr  output  ADDR_W+2  byte address of the write; bits [1:0] always 0
- imem_wdata  output  32  word to write
- cpu_run  output  1  1 = core released from reset; drives the core's active-low reset
- busy  output  1  load in progress
- done  output  1  last load completed without error (level)
- err  output  1  last load aborted (level)

Behaviour:
- Reset values: all outputs 0; state IDLE; word counter, byte counter and length register 0.
- States: IDLE, LEN_HI, LEN_LO, DATA, DONE, ERR (CHK when the optional feature is compiled in).
- start in IDLE, DONE or ERR: next state LEN_HI. Same edge clears done, err and cpu_run and sets busy. start is ignored in every other state.
- in_ready = 1 in LEN_HI, LEN_LO and DATA (and CHK); 0 in all other states. The loader never stalls mid-image.
- LEN_HI: accepted byte becomes len[15:8]. LEN_LO: accepted byte becomes len[7:0].
- After LEN_LO:
  - len == 0 -> DONE (or CHK).
  - len > 2**ADDR_W -> ERR.
  - otherwise -> DATA.
- DATA packing: bytes are big-endian; the first byte of each group of four is wdata[31:24].
- Write timing: the cycle after the 4th byte of a word is accepted, imem_we = 1 for exactly one cycle.
  - imem_wdata = the packed word.
  - imem_addr = word_index*4, with word_index starting at 0.
  - imem_addr and imem_wdata hold their values when imem_we = 0.
- Bytes may keep arriving back-to-back: the 1st byte of word N+1 may be accepted in the same cycle as word N's write.
- When word len-1 is written (in that write cycle) -> DONE (or CHK).
- Entering DONE: busy = 0, done = 1, cpu_run = 1 on the following cycle and thereafter.
- ERR: busy = 0, err = 1, cpu_run = 0, in_ready = 0. Extra stream bytes are left unconsumed.
- Counter width: the word counter is ADDR_W+1 bits; len == 2**ADDR_W is legal and fills the whole memory.
- Gaps in in_valid of any length are tolerated in every receiving state.
- rst mid-load: returns to IDLE the next cycle and discards the partial word. No imem_we is issued on or after the reset edge. cpu_run = 0.

Optional Feature:
- Macro: IMEM_LOADER_CKSUM_EN.
- With the macro defined:
  - A running 8-bit XOR covers every DATA byte.
  - After the last word, state CHK accepts one checksum byte.
  - Byte == XOR: DONE.
  - Byte != XOR: ERR. Words already written remain in memory, but cpu_run stays 0.
  - len == 0 goes to CHK with an expected XOR of 0x00.
- Without the macro: no CHK state and no checksum byte; behaviour exactly as above.

Test Plan:
- Basic load: rst, start, stream 00 02 20 08 00 05 AC 08 00 00.
  - imem_we pulses at addr 0x000, wdata 0x20080005.
  - imem_we pulses at addr 0x004, wdata 0xAC080000.
  - done = 1 and cpu_run = 1, with exactly 2 write strobes.
- Throttled input: same image with in_valid toggled 1-0-0-1 randomly -> identical writes and addresses, and no extra strobes.
- Length bound: ADDR_W = 8.
  - len 0x0100 -> 256 writes, last at addr 0x3FC, then done.
  - len 0x0101 -> err = 1, in_ready = 0, no writes, cpu_run = 0.
- Zero length and restart:
  - len 0x0000 -> done with no writes.
  - start again -> cpu_run drops to 0 the cycle after start, busy = 1.
- Reset mid-word: rst asserted after 2 of the 4 bytes of word 1 -> no write for word 1, cpu_run = 0.
  - Fresh start and full 1-word image 00 01 12 34 56 78 -> write 0x12345678 at addr 0.
- Checksum (IMEM_LOADER_CKSUM_EN): image 00 01 12 34 56 78.
  - Followed by 08 -> done.
  - Followed by 09 -> err, cpu_run = 0, word still written at addr 0.
